// File: rtl/adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_ctrl_pkg
//  Description : Shared types and helpers for the nibble-serial adder
//                sequencer (state encoding, slice width, nibble selector).
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W    = 4;
  localparam int MAX_NIBBLES = 8;
  localparam int MAX_W       = NIBBLE_W * MAX_NIBBLES;
  localparam int MAX_IDX_W   = 3;

  // Select nibble 'idx' of a vector zero-extended to the maximum width
  function automatic logic [NIBBLE_W-1:0] nib(input logic [MAX_W-1:0]     vec,
                                              input logic [MAX_IDX_W-1:0] idx);
    return vec[{idx, 2'b00} +: NIBBLE_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/four_bit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : four_bit_adder
//  Description : Combinational 4-bit adder with carry-in, carry-out and
//                two's-complement overflow (carry into MSB xor carry out).
//  Revision    : 1.0 - initial release
// ============================================================================
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout,
  output logic       overfl
);

  logic [4:0] w_full;
  logic [3:0] w_low;

  // Full sum plus the 3-bit partial sum whose MSB is the carry into bit 3
  always_comb begin
    w_full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    w_low  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
    y      = w_full[3:0];
    cout   = w_full[4];
    overfl = w_low[3] ^ w_full[4];
  end

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder_ctrl
//  Description : WIDTH-bit add/subtract performed one nibble per clock on a
//                single shared four_bit_adder, LSB nibble first, with the
//                carry chained through a register. Result is published with
//                a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          sub,
  input  logic [NIBBLES*NIBBLE_W-1:0]   in_a,
  input  logic [NIBBLES*NIBBLE_W-1:0]   in_b,
  input  logic                          cin,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLES*NIBBLE_W-1:0]   sum,
  output logic                          cout,
  output logic                          overfl
);

  localparam int WIDTH = NIBBLES * NIBBLE_W;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     work_q;
  logic [WIDTH-1:0]     sum_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 carry_q;
  logic                 done_q;
  logic                 cout_q;
  logic                 overfl_q;

  logic [MAX_W-1:0]     w_a_ext;
  logic [MAX_W-1:0]     w_b_ext;
  logic [MAX_IDX_W-1:0] w_idx_ext;
  logic [NIBBLE_W-1:0]  w_add_a;
  logic [NIBBLE_W-1:0]  w_add_b;
  logic [NIBBLE_W-1:0]  w_add_y;
  logic                 w_add_cout;
  logic                 w_add_ovf;
  logic [WIDTH-1:0]     sum_d;

  // Present the current operand nibbles to the shared adder
  always_comb begin
    w_a_ext                   = '0;
    w_a_ext[WIDTH-1:0]        = a_q;
    w_b_ext                   = '0;
    w_b_ext[WIDTH-1:0]        = b_q;
    w_idx_ext                 = '0;
    w_idx_ext[IDX_W-1:0]      = idx_q;
    w_add_a                   = nib(w_a_ext, w_idx_ext);
    w_add_b                   = nib(w_b_ext, w_idx_ext);
  end

  four_bit_adder u_adder (
    .a      (w_add_a),
    .b      (w_add_b),
    .cin    (carry_q),
    .y      (w_add_y),
    .cout   (w_add_cout),
    .overfl (w_add_ovf)
  );

  // Final result: the MSB nibble straight from the adder over the lower work nibbles
  always_comb begin
    sum_d                       = work_q;
    sum_d[WIDTH-1 -: NIBBLE_W]  = w_add_y;
  end

  // Sequencer: capture operands, step one nibble per edge, publish result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      sum_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      overfl_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1, so invert B and force the carry
            a_q     <= in_a;
            b_q     <= sub ? ~in_b : in_b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            work_q  <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) begin
              work_q[n*NIBBLE_W +: NIBBLE_W] <= w_add_y;
            end
          end
          carry_q <= w_add_cout;
          if (idx_q == LAST_IDX) begin
            sum_q    <= sum_d;
            cout_q   <= w_add_cout;
            overfl_q <= w_add_ovf;
            done_q   <= 1'b1;
            idx_q    <= '0;
            state_q  <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign sum    = sum_q;
  assign cout   = cout_q;
  assign overfl = overfl_q;

endmodule
`default_nettype wire
